// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between a CPU, which always wins combinationally, and a
// byte-wide loader DMA port. A boot sequence first reads the scandoubler settings byte.
//
// Handshakes: dmaReq is a level request. The loader holds dmaReq, dmaWr, dmaA and dmaD
// until dmaAck pulses for one clock; the transfer is complete in that clock. dmaQ is valid
// from that pulse onward. If dmaReq is still high in the clock after dmaAck, a new
// transfer starts. The CPU side has no handshake: while cpuMreq and a strobe are low, the
// SRAM pins follow the CPU in the same clock.
module sram_arbiter #(
    parameter logic [20:0] CFG_ADDR  = 21'h08FD5,
    parameter int          INIT_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpuMreq,
    input  logic        cpuRd,
    input  logic        cpuWr,
    input  logic [20:0] cpuA,
    input  logic [7:0]  cpuD,
    output logic [7:0]  cpuQ,
    input  logic        dmaReq,
    input  logic        dmaWr,
    input  logic [20:0] dmaA,
    input  logic [7:0]  dmaD,
    output logic [7:0]  dmaQ,
    output logic        dmaAck,
    output logic        ready,
    output logic [1:0]  cfg,
    output logic        sramWe,
    inout  wire  [7:0]  sramDQ,
    output logic [20:0] sramA,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        CFG  = 3'd1,
        IDLE = 3'd2,
        DMA1 = 3'd3,
        DMA2 = 3'd4
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(INIT_WAIT - 1);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [20:0] addr_q;
    logic [7:0]  data_q;
    logic        wr_q;
    logic        cpu_active;
    logic        dq_oe;
    logic [7:0]  dq_out;

    assign cpu_active = ready && !cpuMreq && (!cpuRd || !cpuWr);
    assign fsm_state  = state;
    assign cpuQ       = sramDQ;
    assign sramDQ     = dq_oe ? dq_out : 8'hzz;

    // The DMA write strobe is also gated by reset so a reset landing in DMA2 never writes.
    always_comb begin
        sramA  = cpuA;
        sramWe = 1'b1;
        dq_oe  = 1'b0;
        dq_out = cpuD;
        if (cpu_active) begin
            sramWe = cpuWr | cpuMreq;
            dq_oe  = !(cpuWr | cpuMreq);
        end else begin
            case (state)
                BOOT, CFG: sramA = CFG_ADDR;
                DMA1: begin
                    sramA  = addr_q;
                    dq_out = data_q;
                    dq_oe  = wr_q && reset;
                end
                DMA2: begin
                    sramA  = addr_q;
                    dq_out = data_q;
                    dq_oe  = wr_q && reset;
                    sramWe = !(wr_q && reset);
                end
                default: sramA = cpuA;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= BOOT;
            wait_cnt <= 4'd0;
            ready    <= 1'b0;
            cfg      <= 2'b00;
            dmaQ     <= 8'h00;
            dmaAck   <= 1'b0;
            addr_q   <= 21'd0;
            data_q   <= 8'h00;
            wr_q     <= 1'b0;
        end else begin
            dmaAck <= 1'b0;
            case (state)
                BOOT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_cnt == LAST_WAIT) begin
                        state <= CFG;
                    end
                end
                CFG: begin
                    cfg   <= sramDQ[1:0];
                    ready <= 1'b1;
                    state <= IDLE;
                end
                IDLE: begin
                    if (!cpu_active && dmaReq) begin
                        addr_q <= dmaA;
                        data_q <= dmaD;
                        wr_q   <= dmaWr;
                        state  <= DMA1;
                    end
                end
                DMA1: begin
                    // A withdrawn request is dropped before any strobe was issued.
                    if (!dmaReq) begin
                        state <= IDLE;
                    end else if (cpu_active) begin
                        state <= DMA1;
                    end else begin
                        state <= DMA2;
                    end
                end
                DMA2: begin
                    if (cpu_active) begin
                        state <= DMA1;
                    end else begin
                        if (!wr_q) begin
                            dmaQ <= sramDQ;
                        end
                        dmaAck <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM on the shared bus, boot, DMA write/read,
// back-to-back DMA, CPU preemption, abort and reset in mid transfer.
module tb_sram_arbiter;

    localparam logic [20:0] CFG_ADDR = 21'h08FD5;

    logic        clock;
    logic        reset;
    logic        cpuMreq, cpuRd, cpuWr;
    logic [20:0] cpuA;
    logic [7:0]  cpuD;
    logic [7:0]  cpuQ;
    logic        dmaReq, dmaWr;
    logic [20:0] dmaA;
    logic [7:0]  dmaD;
    logic [7:0]  dmaQ;
    logic        dmaAck;
    logic        ready;
    logic [1:0]  cfg;
    logic        sramWe;
    wire  [7:0]  sram_dq;
    logic [20:0] sramA;
    logic [2:0]  fsm_state;

    logic [7:0]  mem [0:2**21-1];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_dmaq;
    int          vectors;
    int          miscompares;
    logic        tb_drive;

    sram_arbiter #(.CFG_ADDR(CFG_ADDR), .INIT_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpuMreq(cpuMreq), .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ),
        .dmaReq(dmaReq), .dmaWr(dmaWr), .dmaA(dmaA), .dmaD(dmaD), .dmaQ(dmaQ), .dmaAck(dmaAck),
        .ready(ready), .cfg(cfg), .sramWe(sramWe), .sramDQ(sram_dq), .sramA(sramA),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // SRAM model: drives when not strobed and no writer owns the bus; writes mid-cycle.
    assign tb_drive = sramWe && !dmaWr && !(!cpuMreq && !cpuWr);
    assign sram_dq  = tb_drive ? mem[sramA] : 8'hzz;

    always @(negedge clock) begin
        if (sramWe === 1'b0) mem[sramA] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every ack pops the dmaQ value expected for that transfer
    always @(negedge clock) begin
        if (dmaAck === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_ack", 32'd1, 32'd0);
            else check("dmaq", {24'd0, dmaQ}, {24'd0, exp_q.pop_front()});
        end
    end

    // driver tasks
    task automatic wait_ack(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end while (dmaAck !== 1'b1 && n < 50);
        if (dmaAck !== 1'b1) check(tag, 32'd0, 32'd1);
    endtask

    task automatic dma_xfer(input logic wr, input logic [20:0] a, input logic [7:0] d,
                            output int lat, output int we_low);
        if (wr) exp_q.push_back(exp_dmaq);
        else begin
            exp_dmaq = mem[a];
            exp_q.push_back(exp_dmaq);
        end
        dmaReq = 1'b1; dmaWr = wr; dmaA = a; dmaD = d;
        lat = 0; we_low = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (sramWe === 1'b0) we_low++;
        end while (dmaAck !== 1'b1 && lat < 50);
        if (dmaAck !== 1'b1) check("dma_ack_timeout", 32'd0, 32'd1);
        dmaReq = 1'b0; dmaWr = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic boot_check(input logic [1:0] exp_cfg);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (i <= 4) check("boot_addr", {11'd0, sramA}, {11'd0, CFG_ADDR});
            if (i == 4) check("boot_not_ready", {31'd0, ready}, 32'd0);
        end
        check("boot_ready", {31'd0, ready}, 32'd1);
        check("boot_cfg", {30'd0, cfg}, {30'd0, exp_cfg});
        @(posedge clock); #1;
    endtask

    initial begin
        int lat, we_low, n;
        logic [20:0] ra;
        logic [7:0]  rd;
        vectors = 0; miscompares = 0; exp_dmaq = 8'h00;
        reset = 1'b0;
        cpuMreq = 1'b1; cpuRd = 1'b1; cpuWr = 1'b1; cpuA = 21'd0; cpuD = 8'h00;
        dmaReq = 1'b0; dmaWr = 1'b0; dmaA = 21'd0; dmaD = 8'h00;
        mem[CFG_ADDR] = 8'h02;
        mem[21'h1FFFF] = 8'h5A;
        mem[21'h00200] = 8'h11;
        mem[21'h00300] = 8'h22;

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_cfg", {30'd0, cfg}, 32'd0);
        check("rst_ack", {31'd0, dmaAck}, 32'd0);
        check("rst_we", {31'd0, sramWe}, 32'd1);
        check("rst_state", {29'd0, fsm_state}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        boot_check(2'b10);

        // DMA write
        dma_xfer(1'b1, 21'h00100, 8'hA5, lat, we_low);
        check("wr_latency", lat, 32'd3);
        check("wr_we_cycles", we_low, 32'd1);
        check("wr_mem", {24'd0, mem[21'h00100]}, 32'h0000_00A5);

        // DMA read
        dma_xfer(1'b0, 21'h1FFFF, 8'h00, lat, we_low);
        check("rd_latency", lat, 32'd3);
        check("rd_we_cycles", we_low, 32'd0);

        // back-to-back reads with dmaReq held across the ack
        exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        dmaReq = 1'b1; dmaWr = 1'b0; dmaA = 21'h1FFFF;
        wait_ack("b2b_first_timeout", n);
        wait_ack("b2b_second_timeout", n);
        check("b2b_spacing", n, 32'd3);
        dmaReq = 1'b0;
        @(posedge clock); #1;

        // random write/readback pairs
        for (int k = 0; k < 4; k++) begin
            ra = 21'($urandom_range(21'h00400, 21'h1FFFFF));
            rd = 8'($urandom_range(0, 255));
            dma_xfer(1'b1, ra, rd, lat, we_low);
            check("rnd_mem", {24'd0, mem[ra]}, {24'd0, rd});
            dma_xfer(1'b0, ra, 8'h00, lat, we_low);
            check("rnd_rd_latency", lat, 32'd3);
        end

        // CPU preempts a DMA write sitting in DMA2
        exp_q.push_back(exp_dmaq);
        dmaReq = 1'b1; dmaWr = 1'b1; dmaA = 21'h00200; dmaD = 8'h77;
        @(posedge clock); #1;
        @(posedge clock); #1;
        cpuMreq = 1'b0; cpuWr = 1'b0; cpuA = 21'h04000; cpuD = 8'h3C;
        @(negedge clock);
        check("pre_cpu_we", {31'd0, sramWe}, 32'd0);
        check("pre_cpu_addr", {11'd0, sramA}, 32'h0000_4000);
        @(posedge clock); #1;
        cpuMreq = 1'b1; cpuWr = 1'b1;
        @(negedge clock);
        check("pre_no_ack", {31'd0, dmaAck}, 32'd0);
        check("pre_cpu_mem", {24'd0, mem[21'h04000]}, 32'h0000_003C);
        check("pre_dma_mem_old", {24'd0, mem[21'h00200]}, 32'h0000_0011);
        wait_ack("pre_retry_timeout", n);
        check("pre_retry_latency", n, 32'd2);
        check("pre_dma_mem_new", {24'd0, mem[21'h00200]}, 32'h0000_0077);
        dmaReq = 1'b0; dmaWr = 1'b0;
        @(posedge clock); #1;

        // CPU read while idle
        cpuMreq = 1'b0; cpuRd = 1'b0; cpuA = 21'h04000;
        @(negedge clock);
        check("cpu_rd_q", {24'd0, cpuQ}, 32'h0000_003C);
        check("cpu_rd_we", {31'd0, sramWe}, 32'd1);
        @(posedge clock); #1;
        cpuMreq = 1'b1; cpuRd = 1'b1;

        // abort in DMA1
        dmaReq = 1'b1; dmaWr = 1'b1; dmaA = 21'h00300; dmaD = 8'h99;
        @(posedge clock); #1;
        dmaReq = 1'b0;
        @(posedge clock); #1;
        check("abort_state", {29'd0, fsm_state}, 32'd2);
        repeat (3) @(posedge clock);
        #1;
        dmaWr = 1'b0;
        check("abort_mem", {24'd0, mem[21'h00300]}, 32'h0000_0022);

        // reset lands in DMA2 of a new write
        dmaReq = 1'b1; dmaWr = 1'b1; dmaA = 21'h00300; dmaD = 8'h99;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rstdma_we", {31'd0, sramWe}, 32'd1);
        @(posedge clock); #1;
        dmaReq = 1'b0; dmaWr = 1'b0;
        @(negedge clock);
        check("rstdma_state", {29'd0, fsm_state}, 32'd0);
        check("rstdma_ready", {31'd0, ready}, 32'd0);
        check("rstdma_ack", {31'd0, dmaAck}, 32'd0);
        check("rstdma_dmaq", {24'd0, dmaQ}, 32'd0);
        check("rstdma_mem", {24'd0, mem[21'h00300]}, 32'h0000_0022);
        exp_dmaq = 8'h00;

        // second boot picks up a new setting, which then persists
        mem[CFG_ADDR] = 8'h03;
        @(posedge clock); #1;
        reset = 1'b1;
        boot_check(2'b11);
        dma_xfer(1'b1, CFG_ADDR, 8'h01, lat, we_low);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("cfg_persist", {30'd0, cfg}, 32'd3);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
